if_prefetch_queue: RTL and testbench
====================================

# if_prefetch_queue

Instruction prefetch queue between instruction memory and the pipeline's IF/ID register. The queue runs ahead of the pipeline: it fetches sequential instruction words into a small FIFO and hands them out one at a time, together with pc and pc+4, whenever the IF/ID stage can accept one. It is flushed and redirected on every taken branch, j or jr. A hazard stall only pauses the consumer side; fetching continues until the queue is full.

## Interface
- DEPTH, 4 — FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0 — fetch address after reset.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address presented to instruction memory; equals the internal fetch pc.
- imem_inst  in  32  instruction word at imem_addr, combinational read, valid in the same cycle.
- flush  in  1  redirect request (PCSrc, j or jr resolved in ID).
- flush_pc  in  32  redirect target (BranchAddr or JumpTarget).
- out_ready  in  1  consumer accepts this cycle (IFIDWrite).
- out_valid  out  1  head entry is valid.
- out_inst  out  32  head instruction; 32'h0 (nop) when out_valid=0.
- out_pc  out  32  address of the head instruction.
- out_pc_plus_4  out  32  out_pc + 4.
- level  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State: fetch pc `fpc`, write pointer, read pointer, `count`. Each entry stores {pc, inst}.
- pop = out_valid & out_ready & ~flush.
- push = ~flush & (count < DEPTH | pop). Exception: a bypass pop (see Configuration) does not push.
- On push:
  - Store {fpc, imem_inst} at the write pointer.
  - fpc <= fpc + 4. Wraps modulo 2^32, no carry-out.
- On pop: advance the read pointer.
- Count: incremented on push only, decremented on pop only, unchanged when both occur.
- Pointers: wrap modulo DEPTH.
- Flush has priority over push and pop:
  - count <= 0 and both pointers <= 0.
  - fpc <= flush_pc. The low 2 bits of flush_pc are forced to 0.
  - Any pop in the flush cycle is discarded; the consumer is flushed in the same cycle.
- Full (count=DEPTH) with pop: push and pop happen in the same cycle and count stays DEPTH.
- Empty (count=0) with out_ready=1: no pop. out_valid=0 unless bypass is active.
- Outputs out_* are driven combinationally from the head entry.
- level = count.

## Timing
- Reset (asynchronous assert, synchronous release to clock):
  - fpc=RESET_PC, count=0, pointers=0.
  - out_valid=0, out_inst=0, out_pc=0, out_pc_plus_4=4, level=0, imem_addr=RESET_PC.
- Reset asserted mid-operation: every entry is invalidated immediately, without waiting for a clock edge.
- Fill latency, bypass off: the first edge after reset release or after a flush writes entry 0, and out_valid=1 from that edge onward.
- Throughput: one instruction per cycle, sustained, with out_ready=1.
- Stall: with out_ready=0 the queue fills after DEPTH edges, then fpc holds and imem_addr is stable.
- Redirect: the flush edge loads fpc. out_valid=0 for the next cycle, and the first target instruction appears one edge later (bypass off).

## Configuration
- IF_PREFETCH_BYPASS_EN defined:
  - When count=0 and flush=0, out_valid=1 with out_inst=imem_inst and out_pc=fpc, all combinational.
  - If out_ready=1 in that cycle, the word is consumed directly: fpc += 4, no push.
  - If out_ready=0, the word is pushed normally.
  - Result: zero fill latency after reset or flush.
- IF_PREFETCH_BYPASS_EN undefined: output comes from the FIFO only, with 1-cycle fill latency as specified above.

## Test plan
- Reset: hold reset_n=0, then release.
  - While held: out_valid=0, level=0, imem_addr=0.
  - After release with out_ready=1: out_pc sequence 0,4,8,… one per cycle; out_inst matches instructmem[0..]; out_pc_plus_4 = out_pc + 4.
- Stall fill, out_ready=0 with DEPTH=4:
  - After 4 edges: level=4, imem_addr=16, out_pc=0 held.
  - Set out_ready=1: pcs 0,4,8,12,16 on consecutive cycles with no bubble.
- Full with simultaneous push and pop: level stays 4 across 10 cycles of out_ready=1; out_pc increments by 4 every cycle.
- Flush: assert flush with flush_pc=32'hC8 while level=3.
  - Next cycle: level=0, imem_addr=C8; out_valid=0 (bypass off) or out_pc=C8 (bypass on).
  - Then out_pc C8, CC, …
- Flush while out_ready=1 and full: no entry is popped, no stale pc appears afterwards, and flush_pc=32'hCB is fetched as C8.
- Reset mid-stream at level=2: out_valid falls immediately without a clock edge; after release the sequence restarts at pc 0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction prefetch queue that sits between instruction memory and the
// IF/ID pipeline register. It fetches sequential instruction words ahead of
// the pipeline into a small FIFO. It hands them out one at a time, together
// with their pc and pc+4, whenever the consumer (IF/ID) accepts one. A taken
// branch, j or jr flushes the queue and redirects fetching. A consumer stall
// only pauses draining; fetching continues until the queue is full.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   imem_addr      out  byte address to instruction memory (= fetch pc)
//   imem_inst      in   instruction word at imem_addr (combinational read)
//   flush          in   redirect request (taken branch / j / jr)
//   flush_pc       in   redirect target; low two bits are ignored
//   out_ready      in   consumer accepts the head entry this cycle
//   out_valid      out  head entry valid
//   out_inst       out  head instruction, 32'h0 when out_valid = 0
//   out_pc         out  address of head instruction
//   out_pc_plus_4  out  out_pc + 4
//   level          out  current occupancy
//
// Configuration
//   IF_PREFETCH_BYPASS_EN  when defined, an empty queue presents the word
//                          currently being fetched directly on the outputs.
//                          This gives zero fill latency after reset or flush.
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_inst,
  input  logic                         flush,
  input  logic [31:0]                  flush_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointer arithmetic relies on natural wrap-around, so DEPTH must be a
  // power of two.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_prefetch_queue: DEPTH must be a power of two and at least 2");
  end

  // Storage and control state
  logic [31:0]      r_mem_pc   [DEPTH];
  logic [31:0]      r_mem_inst [DEPTH];
  logic [31:0]      r_fpc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Handshake decode
  logic w_empty;
  logic w_not_full;
  logic w_bypass;
  logic w_valid;
  logic w_fifo_pop;
  logic w_bypass_pop;
  logic w_push;
  logic w_advance;

  // Occupancy flags and the bypass qualifier
  always_comb begin
    w_empty    = (r_count == {CNT_W{1'b0}});
    w_not_full = (r_count < CNT_W'(DEPTH));
`ifdef IF_PREFETCH_BYPASS_EN
    // Reset is included so the bypass path cannot show a word while the
    // queue is held in reset.
    w_bypass   = w_empty & ~flush & reset_n;
`else
    w_bypass   = 1'b0;
`endif
  end

  // Push / pop / fetch-advance decisions
  always_comb begin
    w_valid      = ~w_empty | w_bypass;
    // Real FIFO pop only when an entry exists; a flush discards the pop.
    w_fifo_pop   = ~w_empty & out_ready & ~flush;
    // Word taken straight from memory: consumed without entering the FIFO.
    w_bypass_pop = w_bypass & out_ready;
    // When full, a simultaneous pop frees the slot that this push reuses.
    w_push       = ~flush & (w_not_full | w_fifo_pop) & ~w_bypass_pop;
    w_advance    = w_push | w_bypass_pop;
  end

  // Fetch pc, pointers, count and entry storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fpc    <= RESET_PC;
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= 32'h0000_0000;
        r_mem_inst[i] <= 32'h0000_0000;
      end
    end else if (flush) begin
      // Redirect wins over any push or pop in this cycle.
      r_fpc    <= {flush_pc[31:2], 2'b00};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]   <= r_fpc;
        r_mem_inst[r_wr_ptr] <= imem_inst;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_advance) begin
        r_fpc <= r_fpc + 32'd4;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_fifo_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_fifo_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Head-of-queue output mux
  always_comb begin
    out_valid = w_valid;
    imem_addr = r_fpc;
    level     = r_count;
    if (!w_empty) begin
      out_inst = r_mem_inst[r_rd_ptr];
      out_pc   = r_mem_pc[r_rd_ptr];
    end else if (w_bypass) begin
      out_inst = imem_inst;
      out_pc   = r_fpc;
    end else begin
      out_inst = 32'h0000_0000;
      out_pc   = 32'h0000_0000;
    end
    out_pc_plus_4 = out_pc + 32'd4;
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// Self-checking bench for if_prefetch_queue (DEPTH = 4, RESET_PC = 0).
// The reference model keeps the queue as a list of fetched pcs plus the
// fetch pc. Instruction words are a fixed function of their address, so the
// expected out_inst follows from the expected out_pc.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [2:0]  level;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_inst    (imem_inst),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_pc_plus_4(out_pc_plus_4),
    .level        (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
  endfunction

  // Instruction memory: combinational read
  assign imem_inst = inst_of(imem_addr);

  function automatic logic exp_valid();
    return (m_q.size() > 0) || (BYP && !flush && reset_n);
  endfunction

  function automatic logic [31:0] exp_pc();
    if (m_q.size() > 0) return m_q[0];
    if (exp_valid()) return m_fpc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return exp_valid() ? inst_of(exp_pc()) : 32'h0;
  endfunction

  task automatic drive(input logic fl, input logic [31:0] fp, input logic rdy);
    flush     = fl;
    flush_pc  = fp;
    out_ready = rdy;
    #1;
  endtask

  // One clock edge; the model follows the rules of the queue at that edge.
  task automatic tick();
    int  n;
    bit  popped;
    @(posedge clock);
    n = m_q.size();
    popped = 1'b0;
    if (flush) begin
      m_q.delete();
      m_fpc = flush_pc & ~32'h3;
    end else if (n == 0 && BYP && out_ready) begin
      m_fpc = m_fpc + 32'd4;
    end else begin
      if (n > 0 && out_ready) begin
        void'(m_q.pop_front());
        popped = 1'b1;
      end
      if (n < DEPTH || popped) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    out_ready = 1'b0;
    m_q.delete();
    m_fpc = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    out_ready = 1'b1;
    m_q.delete();
    m_fpc = 32'h0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", level); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got=%h want=0", out_inst); end
    n_cmp++; if (out_pc !== 32'h0 || out_pc_plus_4 !== 32'h4) begin
      n_bad++; $display("FAIL reset_pc got=%h/%h want=0/4", out_pc, out_pc_plus_4);
    end
    reset_n = 1'b1;
    // Stream with out_ready held high: pc 0,4,8,... one per cycle
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== exp_valid()) begin n_bad++; $display("FAIL stream_valid k=%0d got=%0b want=%0b", k, out_valid, exp_valid()); end
      if (exp_valid()) begin
        n_cmp++; if (out_pc !== exp_pc() || out_inst !== exp_inst() || out_pc_plus_4 !== exp_pc() + 32'd4) begin
          n_bad++; $display("FAIL stream_pc k=%0d got=%h/%h/%h want=%h/%h/%h", k, out_pc, out_inst, out_pc_plus_4, exp_pc(), exp_inst(), exp_pc() + 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL stall_level got=%0d want=4", level); end
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL stall_addr got=%h want=10", imem_addr); end
    n_cmp++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_head got=%h/%0b want=0/1", out_pc, out_valid); end
    tick();
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL stall_hold got=%h want=10", imem_addr); end
    // Drain without bubbles: 0,4,8,12,16
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        n_bad++; $display("FAIL drain_pc k=%0d got=%h/%0b want=%h/1", k, out_pc, out_valid, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    // Continues from the stall test: queue stays full while draining
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (level !== 3'd4 || out_pc !== 32'(20 + 4 * k)) begin
        n_bad++; $display("FAIL full_pp k=%0d got=%0d/%h want=4/%h", k, level, out_pc, 32'(20 + 4 * k));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL flush_pre_level got=%0d want=3", level); end
    drive(1'b1, 32'h0000_00C8, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (level !== 3'd0 || imem_addr !== 32'hC8) begin
      n_bad++; $display("FAIL flush_state got=%0d/%h want=0/c8", level, imem_addr);
    end
    n_cmp++; if (BYP ? (out_valid !== 1'b1 || out_pc !== 32'hC8) : (out_valid !== 1'b0)) begin
      n_bad++; $display("FAIL flush_out got=%0b/%h want=%0b/%h", out_valid, out_pc, BYP, BYP ? 32'hC8 : 32'h0);
    end
    if (!BYP) tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(32'hC8 + 4 * k) || out_inst !== inst_of(32'(32'hC8 + 4 * k))) begin
        n_bad++; $display("FAIL flush_seq k=%0d got=%h/%h want=%h", k, out_pc, out_inst, 32'(32'hC8 + 4 * k));
      end
      tick();
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h0000_00CB, 1'b1);
    tick();
    n_cmp++; if (imem_addr !== 32'hC8 || level !== 3'd0) begin
      n_bad++; $display("FAIL flushfull_addr got=%h/%0d want=c8/0", imem_addr, level);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== exp_valid() || (exp_valid() && out_pc !== exp_pc())) begin
        n_bad++; $display("FAIL flushfull_seq k=%0d got=%0b/%h want=%0b/%h", k, out_valid, out_pc, exp_valid(), exp_pc());
      end
      n_cmp++; if (out_valid === 1'b1 && out_pc < 32'hC8) begin
        n_bad++; $display("FAIL flushfull_stale k=%0d got=%h want>=c8", k, out_pc);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1'b1, 32'h0000_0100, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL mid_pre_level got=%0d want=2", level); end
    #2;
    reset_n = 1'b0;
    m_q.delete();
    m_fpc = 32'h0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL mid_async got=%0b/%0d/%h want=0/0/0", out_valid, level, imem_addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== exp_valid() || (exp_valid() && (out_pc !== exp_pc() || out_inst !== exp_inst()))) begin
        n_bad++; $display("FAIL mid_restart k=%0d got=%0b/%h want=%0b/%h", k, out_valid, out_pc, exp_valid(), exp_pc());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        fl;
    logic        rdy;
    logic [31:0] fp;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      fp  = $urandom;
      drive(fl, fp, rdy);
      n_cmp++; if (out_valid !== exp_valid() || out_inst !== exp_inst() || level !== 3'(m_q.size()) || imem_addr !== m_fpc) begin
        n_bad++; $display("FAIL rand_state k=%0d got v=%0b i=%h l=%0d a=%h want v=%0b i=%h l=%0d a=%h", k, out_valid, out_inst, level, imem_addr, exp_valid(), exp_inst(), m_q.size(), m_fpc);
      end
      if (exp_valid()) begin
        n_cmp++; if (out_pc !== exp_pc() || out_pc_plus_4 !== exp_pc() + 32'd4) begin
          n_bad++; $display("FAIL rand_pc k=%0d got=%h/%h want=%h/%h", k, out_pc, out_pc_plus_4, exp_pc(), exp_pc() + 32'd4);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_stall_fill();
    test_full_push_pop();
    test_flush();
    test_flush_full();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
